// File: rtl/venus_pkg.sv
// ============================================================================
// venus_pkg : shared decode constants, control struct and helpers for id_issue
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package venus_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RD_MSB   = 25;
  localparam int RD_LSB   = 21;
  localparam int RS_MSB   = 20;
  localparam int RS_LSB   = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int OPC_IMMF = 2;

  localparam logic [2:0] CLS_INTE  = 3'b000;
  localparam logic [2:0] CLS_LOGIC = 3'b001;
  localparam logic [2:0] CLS_SHIFT = 3'b010;
  localparam logic [2:0] CLS_LD    = 3'b011;
  localparam logic [2:0] CLS_ST    = 3'b100;
  localparam logic [2:0] CLS_BR    = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic inte;
    logic lgc;
    logic shift;
    logic ld;
    logic st;
    logic br;
    logic immf;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  typedef enum logic [0:0] {
    ST_ISSUE  = 1'b0,
    ST_BUBBLE = 1'b1
  } hz_state_e;

  // Invalid class codes decode to BUBBLE, so immf never leaks from them.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opc);
    ctrl_t c;
    c = BUBBLE;
    case (opc[5:3])
      CLS_INTE:  c.inte  = 1'b1;
      CLS_LOGIC: c.lgc   = 1'b1;
      CLS_SHIFT: c.shift = 1'b1;
      CLS_LD:    c.ld    = 1'b1;
      CLS_ST:    c.st    = 1'b1;
      CLS_BR:    c.br    = 1'b1;
      default:   c       = BUBBLE;
    endcase
    if (c != BUBBLE) c.immf = opc[OPC_IMMF];
    return c;
  endfunction

  function automatic logic zext_class(input ctrl_t c);
    return c.lgc | c.shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// id_regfile : 2-read / 1-write architectural register file, r0 hard-wired 0.
//              ID_WB_BYPASS_EN enables write-through from the write port.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module id_regfile
  import venus_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra_addr_i,
  output logic [XLEN-1:0] ra_data_o,
  input  logic [4:0]      rb_addr_i,
  output logic [XLEN-1:0] rb_data_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [0:NREG-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    ra_data_o = '0;
    if (ra_addr_i != REG_ZERO) begin
`ifdef ID_WB_BYPASS_EN
      if (we_i && (waddr_i == ra_addr_i)) ra_data_o = wdata_i;
      else                                ra_data_o = regs_q[ra_addr_i];
`else
      ra_data_o = regs_q[ra_addr_i];
`endif
    end
  end

  always_comb begin
    rb_data_o = '0;
    if (rb_addr_i != REG_ZERO) begin
`ifdef ID_WB_BYPASS_EN
      if (we_i && (waddr_i == rb_addr_i)) rb_data_o = wdata_i;
      else                                rb_data_o = regs_q[rb_addr_i];
`else
      rb_data_o = regs_q[rb_addr_i];
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_issue.sv
// ============================================================================
// id_issue : decode/issue stage feeding EX; load-use bubble, stall and flush.
//            Optional ID_WB_BYPASS_EN makes writeback visible same-cycle.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module id_issue
  import venus_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic            inst_valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] rd_value_o,
  output logic [XLEN-1:0] rs_value_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_value_o,
  output logic            immf_o,
  output logic            ctrl_inte_o,
  output logic            ctrl_logic_o,
  output logic            ctrl_shift_o,
  output logic            ctrl_ld_o,
  output logic            ctrl_st_o,
  output logic            ctrl_br_o,
  output logic            stall_o
);

  logic [5:0]      opc;
  logic [4:0]      rd_f;
  logic [4:0]      rs_f;
  logic [15:0]     imm16;
  logic [XLEN-1:0] rf_rd_data;
  logic [XLEN-1:0] rf_rs_data;

  ctrl_t           ctrl_d;
  logic            issue_ok;
  logic [XLEN-1:0] rd_value_d;
  logic [XLEN-1:0] rs_value_d;
  logic [4:0]      rd_addr_d;
  logic [XLEN-1:0] imm_value_d;
  logic            hazard;

  hz_state_e       state_q;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] rd_value_q;
  logic [XLEN-1:0] rs_value_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] imm_value_q;

  assign opc   = inst_i[OPC_MSB:OPC_LSB];
  assign rd_f  = inst_i[RD_MSB:RD_LSB];
  assign rs_f  = inst_i[RS_MSB:RS_LSB];
  assign imm16 = inst_i[IMM_MSB:IMM_LSB];

  id_regfile #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra_addr_i (rd_f),
    .ra_data_o (rf_rd_data),
    .rb_addr_i (rs_f),
    .rb_data_o (rf_rs_data),
    .we_i      (wb_we_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i)
  );

  always_comb begin
    ctrl_d      = inst_valid_i ? decode_ctrl(opc) : BUBBLE;
    issue_ok    = (ctrl_d != BUBBLE);
    rd_value_d  = '0;
    rs_value_d  = '0;
    rd_addr_d   = REG_ZERO;
    imm_value_d = '0;
    if (issue_ok) begin
      rd_value_d = rf_rd_data;
      rs_value_d = rf_rs_data;
      rd_addr_d  = rd_f;
      if (zext_class(ctrl_d)) imm_value_d = {{(XLEN-16){1'b0}}, imm16};
      else                    imm_value_d = {{(XLEN-16){imm16[15]}}, imm16};
    end
  end

  // Load in EX whose destination the current instruction reads (rd doubles as store data).
  assign hazard = ctrl_q.ld && (rd_addr_q != REG_ZERO) && inst_valid_i &&
                  ((rd_addr_q == rd_f) || (rd_addr_q == rs_f)) && !stall_i;

  assign stall_o = stall_i | ((state_q == ST_ISSUE) && hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ISSUE;
      ctrl_q      <= BUBBLE;
      rd_value_q  <= '0;
      rs_value_q  <= '0;
      rd_addr_q   <= REG_ZERO;
      imm_value_q <= '0;
    end else if (flush_i) begin
      state_q     <= ST_ISSUE;
      ctrl_q      <= BUBBLE;
      rd_value_q  <= '0;
      rs_value_q  <= '0;
      rd_addr_q   <= REG_ZERO;
      imm_value_q <= '0;
    end else if (stall_i) begin
      state_q     <= state_q;
    end else if ((state_q == ST_ISSUE) && hazard) begin
      state_q     <= ST_BUBBLE;
      ctrl_q      <= BUBBLE;
      rd_value_q  <= '0;
      rs_value_q  <= '0;
      rd_addr_q   <= REG_ZERO;
      imm_value_q <= '0;
    end else begin
      state_q     <= ST_ISSUE;
      ctrl_q      <= ctrl_d;
      rd_value_q  <= rd_value_d;
      rs_value_q  <= rs_value_d;
      rd_addr_q   <= rd_addr_d;
      imm_value_q <= imm_value_d;
    end
  end

  assign rd_value_o   = rd_value_q;
  assign rs_value_o   = rs_value_q;
  assign rd_addr_o    = rd_addr_q;
  assign imm_value_o  = imm_value_q;
  assign immf_o       = ctrl_q.immf;
  assign ctrl_inte_o  = ctrl_q.inte;
  assign ctrl_logic_o = ctrl_q.lgc;
  assign ctrl_shift_o = ctrl_q.shift;
  assign ctrl_ld_o    = ctrl_q.ld;
  assign ctrl_st_o    = ctrl_q.st;
  assign ctrl_br_o    = ctrl_q.br;

endmodule

`default_nettype wire

// File: tb/tb_id_issue.sv
// ============================================================================
// tb_id_issue : directed scoreboard bench for id_issue (ID_WB_BYPASS_EN aware)
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_id_issue;

  typedef struct packed {
    logic        chk;
    logic [31:0] rdv;
    logic [31:0] rsv;
    logic [4:0]  rda;
    logic [31:0] imm;
    logic [6:0]  ctl;   // {inte, logic, shift, ld, st, br, immf}
    logic        stl;
  } exp_t;

  localparam logic [5:0] OP_INTE_I  = 6'b000100;
  localparam logic [5:0] OP_INTE_R  = 6'b000000;
  localparam logic [5:0] OP_LOGIC_I = 6'b001100;
  localparam logic [5:0] OP_SHIFT_R = 6'b010000;
  localparam logic [5:0] OP_LD_I    = 6'b011100;
  localparam logic [5:0] OP_LD_R    = 6'b011000;
  localparam logic [5:0] OP_ST_I    = 6'b100100;
  localparam logic [5:0] OP_BR_R    = 6'b101000;
  localparam logic [5:0] OP_BAD     = 6'b110000;

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_INTE_I = 7'b1000001;
  localparam logic [6:0] C_INTE_R = 7'b1000000;
  localparam logic [6:0] C_LOGI_I = 7'b0100001;
  localparam logic [6:0] C_SHFT_R = 7'b0010000;
  localparam logic [6:0] C_LD_I   = 7'b0001001;
  localparam logic [6:0] C_LD_R   = 7'b0001000;
  localparam logic [6:0] C_ST_I   = 7'b0000101;
  localparam logic [6:0] C_BR_R   = 7'b0000010;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] R9_SAME_CYCLE = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] R9_SAME_CYCLE = 32'h0000_1234;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_valid_i, stall_i, flush_i, wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [4:0]  rd_addr_o;
  logic        immf_o, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o;
  logic        ctrl_ld_o, ctrl_st_o, ctrl_br_o, stall_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_issue #(.NREG(32), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .wb_we_i      (wb_we_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .rd_value_o   (rd_value_o),
    .rs_value_o   (rs_value_o),
    .rd_addr_o    (rd_addr_o),
    .imm_value_o  (imm_value_o),
    .immf_o       (immf_o),
    .ctrl_inte_o  (ctrl_inte_o),
    .ctrl_logic_o (ctrl_logic_o),
    .ctrl_shift_o (ctrl_shift_o),
    .ctrl_ld_o    (ctrl_ld_o),
    .ctrl_st_o    (ctrl_st_o),
    .ctrl_br_o    (ctrl_br_o),
    .stall_o      (stall_o)
  );

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic exp_t ex(input logic [31:0] rdv, input logic [31:0] rsv, input logic [4:0] rda,
                              input logic [31:0] imm, input logic [6:0] ctl, input logic stl);
    exp_t e;
    e.chk = 1'b1; e.rdv = rdv; e.rsv = rsv; e.rda = rda; e.imm = imm; e.ctl = ctl; e.stl = stl;
    return e;
  endfunction

  // Drive one cycle of inputs; x describes outputs seen mid-cycle (regs from the prior edge, stall_o now).
  task automatic step(input int id, input logic [31:0] inst, input logic v, input logic s, input logic f,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input exp_t x);
    inst_i = inst; inst_valid_i = v; stall_i = s; flush_i = f;
    wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
    x.rdv[0] = x.rdv[0];
    sb_q.push_back(x);
    $display("step %0d issued", id);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [108:0] got_o, exp_o;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          got_o = {rd_value_o, rs_value_o, rd_addr_o, imm_value_o,
                   ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, immf_o};
          exp_o = {e.rdv, e.rsv, e.rda, e.imm, e.ctl};
          n_cmp++;
          if (got_o !== exp_o) begin
            n_bad++;
            $display("FAIL outputs @%0t: got rd=%h rs=%h rda=%0d imm=%h ctl=%b, want rd=%h rs=%h rda=%0d imm=%h ctl=%b",
                     $time, rd_value_o, rs_value_o, rd_addr_o, imm_value_o, got_o[6:0],
                     e.rdv, e.rsv, e.rda, e.imm, e.ctl);
          end
          n_cmp++;
          if (stall_o !== e.stl) begin
            n_bad++;
            $display("FAIL stall_o @%0t: got %b want %b", $time, stall_o, e.stl);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t z;
    z = ex(32'h0, 32'h0, 5'd0, 32'h0, C_NONE, 1'b0);
    rst = 1'b0; inst_i = '0; inst_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // reset state, idle, register preload
    step(0,  32'h0, 0, 0, 0, 0, 5'd0, 32'h0, z);
    step(1,  32'h0, 0, 0, 0, 1, 5'd3, 32'h0000_0010, z);
    step(2,  ins(OP_INTE_I, 5'd3, 5'd0, 16'hFFFF), 1, 0, 0, 1, 5'd9, 32'h0000_1234, z);
    step(3,  ins(OP_LOGIC_I, 5'd0, 5'd3, 16'h8000), 1, 0, 0, 0, 5'd0, 32'h0,
         ex(32'h10, 32'h0, 5'd3, 32'hFFFF_FFFF, C_INTE_I, 1'b0));
    step(4,  ins(OP_SHIFT_R, 5'd3, 5'd3, 16'h8001), 1, 0, 0, 1, 5'd5, 32'h0000_0055,
         ex(32'h0, 32'h10, 5'd0, 32'h0000_8000, C_LOGI_I, 1'b0));
    // load-use hazard: ld r5 then add reading r5
    step(5,  ins(OP_LD_I, 5'd5, 5'd3, 16'h0004), 1, 0, 0, 0, 5'd0, 32'h0,
         ex(32'h10, 32'h10, 5'd3, 32'h0000_8001, C_SHFT_R, 1'b0));
    step(6,  ins(OP_INTE_R, 5'd6, 5'd5, 16'h0000), 1, 0, 0, 1, 5'd5, 32'h0000_0077,
         ex(32'h55, 32'h10, 5'd5, 32'h0000_0004, C_LD_I, 1'b1));
    step(7,  ins(OP_INTE_R, 5'd6, 5'd5, 16'h0000), 1, 0, 0, 0, 5'd0, 32'h0, z);
    step(8,  32'h0, 0, 0, 0, 0, 5'd0, 32'h0,
         ex(32'h0, 32'h77, 5'd6, 32'h0, C_INTE_R, 1'b0));
    // store frozen under a three-cycle stall, wb r7 inside the window
    step(9,  ins(OP_ST_I, 5'd3, 5'd6, 16'hFFF0), 1, 0, 0, 0, 5'd0, 32'h0, z);
    step(10, ins(OP_INTE_I, 5'd7, 5'd0, 16'h0001), 1, 1, 0, 1, 5'd7, 32'h0000_ABCD,
         ex(32'h10, 32'h0, 5'd3, 32'hFFFF_FFF0, C_ST_I, 1'b1));
    step(11, ins(OP_INTE_I, 5'd7, 5'd0, 16'h0001), 1, 1, 0, 0, 5'd0, 32'h0,
         ex(32'h10, 32'h0, 5'd3, 32'hFFFF_FFF0, C_ST_I, 1'b1));
    step(12, ins(OP_INTE_I, 5'd7, 5'd0, 16'h0001), 1, 1, 0, 0, 5'd0, 32'h0,
         ex(32'h10, 32'h0, 5'd3, 32'hFFFF_FFF0, C_ST_I, 1'b1));
    step(13, ins(OP_INTE_I, 5'd7, 5'd0, 16'h0001), 1, 0, 0, 0, 5'd0, 32'h0,
         ex(32'h10, 32'h0, 5'd3, 32'hFFFF_FFF0, C_ST_I, 1'b0));
    step(14, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0,
         ex(32'h0000_ABCD, 32'h0, 5'd7, 32'h0000_0001, C_INTE_I, 1'b0));
    // flush together with stall beats the hold
    step(15, ins(OP_LD_R, 5'd8, 5'd0, 16'h0000), 1, 0, 0, 0, 5'd0, 32'h0, z);
    step(16, ins(OP_INTE_R, 5'd8, 5'd0, 16'h0000), 1, 1, 1, 0, 5'd0, 32'h0,
         ex(32'h0, 32'h0, 5'd8, 32'h0, C_LD_R, 1'b1));
    step(17, ins(OP_BAD, 5'd3, 5'd3, 16'h1234), 1, 0, 0, 0, 5'd0, 32'h0, z);
    // same-cycle writeback of r9 against a read of r9
    step(18, ins(OP_INTE_R, 5'd9, 5'd9, 16'h0000), 1, 0, 0, 1, 5'd9, 32'hDEAD_BEEF, z);
    step(19, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0,
         ex(R9_SAME_CYCLE, R9_SAME_CYCLE, 5'd9, 32'h0, C_INTE_R, 1'b0));
    step(20, ins(OP_BR_R, 5'd9, 5'd0, 16'h8000), 1, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, z);
    step(21, ins(OP_INTE_R, 5'd0, 5'd0, 16'h0000), 1, 0, 0, 0, 5'd0, 32'h0,
         ex(32'hDEAD_BEEF, 32'h0, 5'd9, 32'hFFFF_8000, C_BR_R, 1'b0));
    step(22, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0,
         ex(32'h0, 32'h0, 5'd0, 32'h0, C_INTE_R, 1'b0));
    step(23, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, z);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
